// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and SRAM-side signal bundle for sram_arbiter
interface sram_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              cs;
  logic              oe;
  logic              rw;
  logic [31:0]       addr_bus;
  logic [DATA_W-1:0] bus_dout;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_din;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_din,
    output ack0, ack1, rdata, busy, cs, oe, rw, addr_bus, bus_dout, bus_oe
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_din,
    input  ack0, ack1, rdata, busy, cs, oe, rw, addr_bus, bus_dout, bus_oe
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester round-robin arbiter for an asynchronous SRAM
// One access at a time: IDLE -> SETUP -> ACCESS -> DONE, strobes decoded from state.
module sram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester that was not served last goes first.
          win_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          we_d    = win_d ? bus.we1 : bus.we0;
          addr_d  = win_d ? bus.addr1 : bus.addr0;
          wdata_d = win_d ? bus.wdata1 : bus.wdata0;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (!we_q) rdata_d = bus.bus_din;
        state_d = DONE;
      end
      DONE: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign strobe       = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.cs       = ~strobe;
  assign bus.oe       = strobe ? we_q : 1'b1;
  assign bus.rw       = strobe ? ~we_q : 1'b1;
  assign bus.bus_oe   = strobe & we_q;
  assign bus.bus_dout = (strobe & we_q) ? wdata_q : '0;
  assign bus.addr_bus = {{(32-ADDR_W){1'b0}}, addr_q};
  assign bus.ack0     = (state_q == DONE) && !win_q;
  assign bus.ack1     = (state_q == DONE) && win_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
// Transaction-level reference model, SRAM model and randomized two-requester traffic.
module tb_sram_arbiter;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();
  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  logic        r_req   [2];
  logic        r_we    [2];
  logic [6:0]  r_addr  [2];
  logic [31:0] r_wdata [2];

  assign ifc.req0   = r_req[0];
  assign ifc.req1   = r_req[1];
  assign ifc.we0    = r_we[0];
  assign ifc.we1    = r_we[1];
  assign ifc.addr0  = r_addr[0];
  assign ifc.addr1  = r_addr[1];
  assign ifc.wdata0 = r_wdata[0];
  assign ifc.wdata1 = r_wdata[1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // SRAM device: drives the data bus while selected for read, stores while rw is low.
  logic [31:0] sram [0:127];
  assign ifc.bus_din = (!ifc.cs && !ifc.oe) ? sram[ifc.addr_bus[6:0]] : 32'h0BAD_F00D;

  initial begin : sram_model
    for (int i = 0; i < 128; i++) sram[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (reset_n && !ifc.cs && !ifc.rw && ifc.bus_oe) sram[ifc.addr_bus[6:0]] = ifc.bus_dout;
    end
  end

  // Reference: one transaction record; outputs follow from its age in cycles.
  bit          m_active;
  int          m_start;
  int          cyc;
  bit          m_who;
  bit          m_we;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  bit          m_last;
  logic [31:0] ref_mem [0:127];

  initial begin : model
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    m_active = 0; m_last = 1; m_rdata = '0; cyc = 0; m_start = 0;
    m_who = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 0; m_last = 1; m_rdata = '0;
      end else begin
        cyc++;
        if (m_active) begin
          if (cyc - m_start == 2 && !m_we) m_rdata = ref_mem[m_addr];
          if (cyc - m_start == 3) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            m_last   = m_who;
            m_active = 0;
          end
        end else if (r_req[0] || r_req[1]) begin
          m_who    = (r_req[0] && r_req[1]) ? !m_last : r_req[1];
          m_we     = r_we[m_who];
          m_addr   = r_addr[m_who];
          m_wdata  = r_wdata[m_who];
          m_start  = cyc;
          m_active = 1;
        end
      end
    end
  end

  initial begin : compare
    int st;
    bit in_acc;
    forever begin
      @(negedge clk);
      st     = cyc - m_start;
      in_acc = m_active && (st <= 1);
      check("busy",   ifc.busy,   m_active);
      check("cs",     ifc.cs,     !in_acc);
      check("oe",     ifc.oe,     in_acc ? m_we : 1'b1);
      check("rw",     ifc.rw,     in_acc ? !m_we : 1'b1);
      check("bus_oe", ifc.bus_oe, in_acc && m_we);
      check("ack0",   ifc.ack0,   m_active && st == 2 && !m_who);
      check("ack1",   ifc.ack1,   m_active && st == 2 && m_who);
      check("rdata",  ifc.rdata,  m_rdata);
      if (in_acc) check("addr_bus", ifc.addr_bus, {25'b0, m_addr});
      if (in_acc && m_we) check("bus_dout", ifc.bus_dout, m_wdata);
      if (!reset_n) begin
        check("rst_addr_bus", ifc.addr_bus, 32'd0);
        check("rst_bus_dout", ifc.bus_dout, 32'd0);
      end
      check("strobe_conflict", !ifc.cs && !ifc.oe && !ifc.rw, 1'b0);
      check("bus_oe_vs_oe",    ifc.bus_oe && !ifc.oe, 1'b0);
    end
  end

  logic        s_cs, s_oe, s_rw, s_bus_oe;
  logic [31:0] s_addr;
  int          c_order [8];
  int          c_at    [8];
  int          c_cnt;
  int          c_overlap;

  task automatic drive(input int n, input bit we, input logic [6:0] addr, input logic [31:0] data);
    r_we[n] = we; r_addr[n] = addr; r_wdata[n] = data; r_req[n] = 1'b1;
  endtask

  task automatic drop_after_ack(input int n);
    @(posedge clk); #1;
    r_req[n] = 1'b0;
  endtask

  task automatic wait_ack(input int n, output int edges);
    bit got;
    got = 0; edges = 0;
    while (!got && edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (edges == 1) begin
        s_cs = ifc.cs; s_oe = ifc.oe; s_rw = ifc.rw; s_bus_oe = ifc.bus_oe; s_addr = ifc.addr_bus;
      end
      if ((n == 0) ? ifc.ack0 : ifc.ack1) got = 1;
    end
    check("ack_within_budget", got, 1'b1);
  endtask

  task automatic collect_acks(input int want);
    int t;
    c_cnt = 0; c_overlap = 0; t = 0;
    while (c_cnt < want && t < 60) begin
      @(negedge clk); t++;
      if (ifc.ack0 && ifc.ack1) c_overlap++;
      if (ifc.ack0 || ifc.ack1) begin
        c_order[c_cnt] = ifc.ack1 ? 1 : 0;
        c_at[c_cnt]    = t;
        c_cnt++;
      end
    end
    check("ack_count", c_cnt, want);
  endtask

  task automatic rand_fields(input int n);
    r_we[n]    = 1'($urandom % 2);
    r_addr[n]  = ($urandom % 9 == 8) ? 7'd127 : 7'($urandom % 8);
    r_wdata[n] = $urandom;
  endtask

  initial begin : stim
    int  e;
    bit  a [2];
    for (int n = 0; n < 2; n++) begin
      r_req[n] = 0; r_we[n] = 0; r_addr[n] = '0; r_wdata[n] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", ifc.cs, 1'b1);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_rdata", ifc.rdata, 32'd0);
    reset_n = 1'b1;

    // Single write from requester 0
    drive(0, 1'b1, 7'd5, 32'hDEADBEEF);
    wait_ack(0, e);
    check("wr_latency", e, 3);
    check("wr_cs", s_cs, 1'b0);
    check("wr_rw", s_rw, 1'b0);
    check("wr_oe", s_oe, 1'b1);
    check("wr_bus_oe", s_bus_oe, 1'b1);
    check("wr_addr", s_addr, 32'd5);
    drop_after_ack(0);

    // Read-back by requester 1
    drive(1, 1'b0, 7'd5, 32'h0);
    wait_ack(1, e);
    check("rd_latency", e, 3);
    check("rd_cs", s_cs, 1'b0);
    check("rd_oe", s_oe, 1'b0);
    check("rd_rw", s_rw, 1'b1);
    check("rd_bus_oe", s_bus_oe, 1'b0);
    check("rd_data", ifc.rdata, 32'hDEADBEEF);
    drop_after_ack(1);

    // Top of the address range
    drive(0, 1'b1, 7'd127, 32'h0000007F);
    wait_ack(0, e);
    drop_after_ack(0);
    drive(0, 1'b0, 7'd127, 32'h0);
    wait_ack(0, e);
    check("top_addr", s_addr, 32'd127);
    check("top_rdata", ifc.rdata, 32'h0000007F);
    drop_after_ack(0);

    // Contention from reset: alternating grants starting with requester 0
    @(posedge clk); #1;
    reset_n = 1'b0;
    drive(0, 1'b0, 7'd1, 32'h0);
    drive(1, 1'b0, 7'd2, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    collect_acks(4);
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    check("tie_first_at", c_at[0], 4);
    for (int i = 0; i < 4; i++) check("tie_order", c_order[i], i % 2);
    for (int i = 1; i < 4; i++) check("tie_spacing", c_at[i] - c_at[i-1], 4);
    check("tie_overlap", c_overlap, 0);
    @(posedge clk); #1;
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Requester 0 held high for three transactions
    drive(0, 1'b0, 7'd3, 32'h0);
    collect_acks(3);
    for (int i = 0; i < 3; i++) check("b2b_who", c_order[i], 0);
    for (int i = 1; i < 3; i++) check("b2b_spacing", c_at[i] - c_at[i-1], 4);
    @(posedge clk); #1;
    r_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during ACCESS of a write aborts it without an ack
    drive(0, 1'b1, 7'd9, 32'hCAFE0009);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_cs", ifc.cs, 1'b1);
    check("abort_oe", ifc.oe, 1'b1);
    check("abort_rw", ifc.rw, 1'b1);
    check("abort_bus_oe", ifc.bus_oe, 1'b0);
    check("abort_busy", ifc.busy, 1'b0);
    check("abort_ack0", ifc.ack0, 1'b0);
    @(posedge clk); #1;
    check("abort_no_ack", ifc.ack0, 1'b0);
    reset_n = 1'b1;
    wait_ack(0, e);
    check("after_abort_latency", e, 3);
    drop_after_ack(0);

    // Randomized traffic, fields scrambled once latched
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      a[0] = ifc.ack0; a[1] = ifc.ack1;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (r_req[n] && a[n]) begin
          if ($urandom % 2 == 1) rand_fields(n);
          else r_req[n] = 1'b0;
        end else if (!r_req[n]) begin
          if ($urandom % 3 == 0) begin
            rand_fields(n);
            r_req[n] = 1'b1;
          end
        end else if (m_active && m_who == n[0]) begin
          rand_fields(n);
        end
      end
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
